// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS register-file side blocks.
//   dump_state_e : state encoding for the register dump sequencer FSM
//   addr_width() : address width for a register file of a given depth
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_SEND = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4
    } dump_state_e;

    // A depth of 1 still needs a 1-bit address port.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_dump_csum.sv
// reg_dump_csum: running sum modulo 2^width of the data beats of one dump.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero the sum (start of a new dump); wins over accumulate
//   accumulate   : add data_in this cycle (a data beat was accepted)
//   data_in      : beat payload
//   sum          : current sum
module reg_dump_csum #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             accumulate,
    input  logic [width-1:0] data_in,
    output logic [width-1:0] sum
);

    logic [width-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear)
            sum_d = '0;
        else if (accumulate)
            sum_d = sum_q + data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer: on start, reads registers first_address..last_address
// (inclusive, wrapping past depth-1 to 0) through one RegisterFile read port
// and streams each word on a valid/ready interface.
//
// Build option: define REG_DUMP_CHECKSUM_EN to append a checksum beat (sum of
// all data beats modulo 2^width) after the last data beat. Without it there is
// no checksum state, out_is_csum is 0 and out_last marks the final data beat.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             request a dump (only honoured in IDLE)
//   abort             end the dump at the next edge
//   first_address     first register, sampled with start
//   last_address      last register (inclusive), sampled with start
//   rf_read_address   RegisterFile read address (read port shared with datapath)
//   rf_read_data      combinational RegisterFile read data
//   out_valid/ready   beat handshake
//   out_data          beat payload
//   out_address       register address of the payload
//   out_last          final beat of the dump
//   out_is_csum       beat carries the checksum
//   busy              not in IDLE
//   done              one-cycle pulse at completion or abort
module reg_dump_sequencer
    import mips_pkg::*;
#(
    parameter  int depth = 32,
    parameter  int width = 16,
    localparam int AW    = addr_width(depth)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [AW-1:0]    first_address,
    input  logic [AW-1:0]    last_address,
    output logic [AW-1:0]    rf_read_address,
    input  logic [width-1:0] rf_read_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic [AW-1:0]    out_address,
    output logic             out_last,
    output logic             out_is_csum,
    output logic             busy,
    output logic             done
);

`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    dump_state_e      state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;       // register being read / last read
    logic [AW-1:0]    end_q, end_d;         // inclusive last register
    logic [width-1:0] data_q, data_d;       // captured beat payload
    logic [AW-1:0]    data_addr_q, data_addr_d;
    logic             data_last_q, data_last_d;

    logic [AW-1:0]    addr_next;
    logic             at_end;
    logic             abort_hit;

    // Explicit wrap so non power-of-two depths step depth-1 -> 0.
    assign addr_next = (addr_q == AW'(depth - 1)) ? '0 : addr_q + AW'(1);
    assign at_end    = (addr_q == end_q);
    assign abort_hit = abort && (state_q == ST_READ || state_q == ST_SEND ||
                                 state_q == ST_CSUM);

    // addr_q only moves on entry to READ, so driving the shared read port
    // straight from it keeps the port steady everywhere else.
    assign rf_read_address = addr_q;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [width-1:0] csum_value;
    logic             csum_clear;
    logic             csum_acc;

    // A beat killed by abort is not delivered, so it is not summed either.
    assign csum_clear = (state_q == ST_IDLE) && start;
    assign csum_acc   = (state_q == ST_SEND) && out_ready && !abort;

    reg_dump_csum #(.width(width)) u_csum (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (csum_clear),
        .accumulate (csum_acc),
        .data_in    (data_q),
        .sum        (csum_value)
    );
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            end_q       <= '0;
            data_q      <= '0;
            data_addr_q <= '0;
            data_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            end_q       <= end_d;
            data_q      <= data_d;
            data_addr_q <= data_addr_d;
            data_last_q <= data_last_d;
        end
    end

    // Next state and datapath
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        end_d       = end_q;
        data_d      = data_q;
        data_addr_d = data_addr_q;
        data_last_d = data_last_q;

        if (abort_hit) begin
            state_d = ST_DONE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_d  = first_address;
                        end_d   = last_address;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    data_d      = rf_read_data;
                    data_addr_d = addr_q;
                    data_last_d = at_end && !CSUM_EN;
                    state_d     = ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (at_end) begin
                            state_d = CSUM_EN ? ST_CSUM : ST_DONE;
                        end else begin
                            addr_d  = addr_next;
                            state_d = ST_READ;
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (out_ready)
                        state_d = ST_DONE;
                end
`endif
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs (from registered state only)
    always_comb begin
        out_valid   = 1'b0;
        out_data    = '0;
        out_address = '0;
        out_last    = 1'b0;
        out_is_csum = 1'b0;
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        unique case (state_q)
            ST_SEND: begin
                out_valid   = 1'b1;
                out_data    = data_q;
                out_address = data_addr_q;
                out_last    = data_last_q;
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                out_valid   = 1'b1;
                out_data    = csum_value;
                out_address = end_q;
                out_last    = 1'b1;
                out_is_csum = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// tb_reg_dump_sequencer: directed bench for reg_dump_sequencer with a
// 32 x 16 register file model. Registers 1..4 hold FA0..FA3, whose sum
// modulo 2^16 is 16'h3E86.
module tb_reg_dump_sequencer;

    localparam int DEPTH = 32;
    localparam int WIDTH = 16;
    localparam int AW    = 5;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    localparam logic [15:0] FA0 = 16'hFA00;
    localparam logic [15:0] FA1 = 16'hFA01;
    localparam logic [15:0] FA2 = 16'hFA02;
    localparam logic [15:0] FA3 = 16'h5083;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             abort;
    logic [AW-1:0]    first_address;
    logic [AW-1:0]    last_address;
    logic [AW-1:0]    rf_read_address;
    logic [WIDTH-1:0] rf_read_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    out_address;
    logic             out_last;
    logic             out_is_csum;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] rf [0:DEPTH-1];
    assign rf_read_data = rf[rf_read_address];

    reg_dump_sequencer #(.depth(DEPTH), .width(WIDTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .first_address   (first_address),
        .last_address    (last_address),
        .rf_read_address (rf_read_address),
        .rf_read_data    (rf_read_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_address     (out_address),
        .out_last        (out_last),
        .out_is_csum     (out_is_csum),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    // Beat capture (filled by collect, compared by the tests)
    logic [WIDTH-1:0] cap_data [0:15];
    logic [AW-1:0]    cap_addr [0:15];
    logic             cap_last [0:15];
    logic             cap_csum [0:15];
    int               cap_iter [0:15];
    int               n_beats;
    bit               got_done;
    logic             lat_valid, lat_busy;

    // Returns at the negedge where the FSM sits in READ for the first word.
    task automatic start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(negedge clk);
        start = 1'b1;
        first_address = f;
        last_address  = l;
        @(negedge clk);
        start     = 1'b0;
        lat_valid = out_valid;
        lat_busy  = busy;
    endtask

    // Records every beat that out_ready accepts; stops at the done pulse.
    task automatic collect(input int max_cycles);
        n_beats  = 0;
        got_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cap_data[i] = 'x; cap_addr[i] = 'x; cap_last[i] = 1'bx;
            cap_csum[i] = 1'bx; cap_iter[i] = -1;
        end
        for (int it = 0; it < max_cycles; it++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (out_valid && out_ready) begin
                if (n_beats < 16) begin
                    cap_data[n_beats] = out_data;
                    cap_addr[n_beats] = out_address;
                    cap_last[n_beats] = out_last;
                    cap_csum[n_beats] = out_is_csum;
                    cap_iter[n_beats] = it;
                end
                n_beats++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        tests_run++;
        if ({out_valid, busy, done, out_last, out_is_csum} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {out_valid, busy, done, out_last, out_is_csum});
        end
        tests_run++;
        if (out_data !== 16'h0 || out_address !== 5'd0 || rf_read_address !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got data=%h addr=%0d rf=%0d expected 0/0/0",
                     out_data, out_address, rf_read_address);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got busy=%b valid=%b expected 0/0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid_dump;
        out_ready = 1'b0;
        start_dump(5'd1, 5'd4);
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_reach_send: got valid=%b expected 1", out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, busy, done, out_last, out_is_csum} !== 5'b0 ||
            out_data !== 16'h0 || out_address !== 5'd0 || rf_read_address !== 5'd0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got v=%b b=%b d=%b data=%h addr=%0d rf=%0d expected all 0",
                     out_valid, busy, done, out_data, out_address, rf_read_address);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_idle: got busy=%b valid=%b expected 0/0", busy, out_valid);
        end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        start_dump(5'd1, 5'd4);
        tests_run++;
        if (lat_valid !== 1'b0 || lat_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_read_cycle: got valid=%b busy=%b expected 0/1", lat_valid, lat_busy);
        end
        collect(40);
        tests_run++;
        if (!got_done || n_beats != 4 + EXTRA) begin
            tests_failed++;
            $display("FAIL basic_count: got beats=%0d done=%0d expected %0d/1",
                     n_beats, got_done, 4 + EXTRA);
        end
        tests_run++;
        if (cap_iter[0] != 1 || cap_iter[1] != 3) begin
            tests_failed++;
            $display("FAIL basic_timing: got beat cycles %0d,%0d expected 1,3", cap_iter[0], cap_iter[1]);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (cap_data[i] !== rf[1+i] || cap_addr[i] !== AW'(1+i) ||
                cap_last[i] !== (i == 3 && EXTRA == 0) || cap_csum[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_beat%0d: got %h@%0d last=%b csum=%b expected %h@%0d last=%b csum=0",
                         i, cap_data[i], cap_addr[i], cap_last[i], cap_csum[i],
                         rf[1+i], 1+i, (i == 3 && EXTRA == 0));
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        tests_run++;
        if (cap_data[4] !== 16'h3E86 || cap_csum[4] !== 1'b1 || cap_last[4] !== 1'b1 ||
            cap_addr[4] !== 5'd4) begin
            tests_failed++;
            $display("FAIL basic_csum: got %h@%0d csum=%b last=%b expected 3e86@4 csum=1 last=1",
                     cap_data[4], cap_addr[4], cap_csum[4], cap_last[4]);
        end
`endif
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b expected 1/1", done, busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_after_done: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        start_dump(5'd1, 5'd4);
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== FA0 || out_address !== 5'd1) begin
            tests_failed++;
            $display("FAIL bp_first: got v=%b %h@%0d expected 1 %h@1", out_valid, out_data, out_address, FA0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== FA1 || out_address !== 5'd2 ||
                rf_read_address !== 5'd2) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got v=%b %h@%0d rf=%0d expected 1 %h@2 rf=2",
                         j, out_valid, out_data, out_address, rf_read_address, FA1);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        collect(40);
        tests_run++;
        if (!got_done || n_beats != 3 + EXTRA ||
            cap_data[0] !== FA1 || cap_addr[0] !== 5'd2 ||
            cap_data[1] !== FA2 || cap_addr[1] !== 5'd3 ||
            cap_data[2] !== FA3 || cap_addr[2] !== 5'd4) begin
            tests_failed++;
            $display("FAIL bp_rest: got n=%0d %h@%0d %h@%0d %h@%0d expected n=%0d %h@2 %h@3 %h@4",
                     n_beats, cap_data[0], cap_addr[0], cap_data[1], cap_addr[1],
                     cap_data[2], cap_addr[2], 3 + EXTRA, FA1, FA2, FA3);
        end
`ifdef REG_DUMP_CHECKSUM_EN
        tests_run++;
        if (cap_data[3] !== 16'h3E86 || cap_csum[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_csum: got %h csum=%b expected 3e86 csum=1", cap_data[3], cap_csum[3]);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_wrap;
        logic [AW-1:0]    exp_addr [0:3];
        logic [WIDTH-1:0] exp_sum;
        exp_addr[0] = 5'd30; exp_addr[1] = 5'd31; exp_addr[2] = 5'd0; exp_addr[3] = 5'd1;
        exp_sum = '0;
        for (int i = 0; i < 4; i++) exp_sum = exp_sum + rf[exp_addr[i]];
        out_ready = 1'b1;
        start_dump(5'd30, 5'd1);
        collect(40);
        tests_run++;
        if (!got_done || n_beats != 4 + EXTRA) begin
            tests_failed++;
            $display("FAIL wrap_count: got beats=%0d done=%0d expected %0d/1", n_beats, got_done, 4 + EXTRA);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== rf[exp_addr[i]] ||
                cap_last[i] !== (i == 3 && EXTRA == 0)) begin
                tests_failed++;
                $display("FAIL wrap_beat%0d: got %h@%0d last=%b expected %h@%0d last=%b",
                         i, cap_data[i], cap_addr[i], cap_last[i],
                         rf[exp_addr[i]], exp_addr[i], (i == 3 && EXTRA == 0));
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        tests_run++;
        if (cap_data[4] !== exp_sum || cap_addr[4] !== 5'd1 || cap_last[4] !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_csum: got %h@%0d last=%b expected %h@1 last=1",
                     cap_data[4], cap_addr[4], cap_last[4], exp_sum);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_abort;
        logic [AW-1:0] seen [0:3];
        int  seen_cnt;
        bit  hit;
        bit  stray;
        seen_cnt = 0;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) seen[i] = 'x;
        out_ready = 1'b1;
        start_dump(5'd1, 5'd4);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) begin
                if (seen_cnt < 4) seen[seen_cnt] = out_address;
                seen_cnt++;
                // Second start while busy, with a different range
                if (seen_cnt == 1) begin
                    start = 1'b1;
                    first_address = 5'd10;
                    last_address  = 5'd12;
                end
                // Third beat offered with out_ready=1: abort must win
                if (out_address == 5'd3) begin
                    abort = 1'b1;
                    hit = 1'b1;
                    break;
                end
            end
        end
        tests_run++;
        if (!hit || seen[0] !== 5'd1 || seen[1] !== 5'd2) begin
            tests_failed++;
            $display("FAIL abort_beats_before: got hit=%0d addrs %0d,%0d expected 1 addrs 1,2",
                     hit, seen[0], seen[1]);
        end
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_next_edge: got valid=%b done=%b busy=%b expected 0/1/1",
                     out_valid, done, busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle: got done=%b busy=%b expected 0/0", done, busy);
        end
        stray = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid || busy) stray = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (stray !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_stray_beat: got activity=%b expected 0", stray);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset_n       = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        out_ready     = 1'b0;
        first_address = '0;
        last_address  = '0;
        for (int i = 0; i < DEPTH; i++) rf[i] = 16'hA000 + 16'(i * 16'h0111);
        rf[1] = FA0; rf[2] = FA1; rf[3] = FA2; rf[4] = FA3;
        repeat (2) @(negedge clk);

        test_reset();
        test_reset_mid_dump();
        test_basic();
        test_backpressure();
        test_wrap();
        test_abort();
        test_basic();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
